// File: rtl/bus_mux_enc_reg.sv
// bus_mux_enc_reg
// Shared datapath bus multiplexer that takes the control unit's one-hot
// "out" enables directly. It encodes them to a priority select (index 0
// wins), drives the bus from the winning source, and watches for more than
// one source driving at once.
//
// Parameters:
//   WIDTH     - width of each source and of the bus
//   N_SRC     - number of sources, index 0 has the highest priority
//   SEL_W     - width of the encoded select, 2**SEL_W >= N_SRC
//   REG_OUT   - 1: bus outputs registered (1-cycle latency), 0: combinational
//   HOLD_IDLE - 1: bus keeps the last driven value when idle, 0: bus drives 0
//
// Ports:
//   clock        - system clock, rising edge
//   clear        - synchronous active-high reset, beats every other input
//   src_data     - flattened source data, source i at [i*WIDTH +: WIDTH]
//   src_en       - per-source drive enables, nominally one-hot
//   conflict_clr - clears the sticky conflict flag
//   bus_out      - bus value
//   bus_valid    - a source drove the bus
//   bus_sel      - index of the winning source
//   conflict     - sticky flag, more than one enable was seen high
//
// Optional feature, macro BUS_CONFLICT_CNT_EN:
//   conflict_cnt - saturating count of conflict edges, zeroed by
//                  clear/conflict_clr
//   conflict_src - src_en captured on the first conflict edge after
//                  clear/conflict_clr

module bus_mux_enc_reg #(
    parameter int WIDTH     = 32,
    parameter int N_SRC     = 24,
    parameter int SEL_W     = 5,
    parameter int REG_OUT   = 1,
    parameter int HOLD_IDLE = 1
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_en,
    input  logic                   conflict_clr,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_valid,
    output logic [SEL_W-1:0]       bus_sel,
    output logic                   conflict
`ifdef BUS_CONFLICT_CNT_EN
    ,
    output logic [7:0]             conflict_cnt,
    output logic [N_SRC-1:0]       conflict_src
`endif
);

    logic [SEL_W-1:0] winSel;
    logic [WIDTH-1:0] winData;
    logic             anyEn;
    logic             multiEn;
    logic [WIDTH-1:0] lastVal;
    logic [SEL_W-1:0] selReg;
    logic [WIDTH-1:0] idleVal;
    logic             conflictReg;

    // Priority encoder: scan from the top down so the lowest enabled index is
    // the last one written and therefore wins.
    always_comb begin
        winSel  = '0;
        winData = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                winSel  = SEL_W'(i);
                winData = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Clearing the lowest set bit leaves something behind exactly when two or
    // more enables are high, which avoids a full popcount.
    assign anyEn   = |src_en;
    assign multiEn = |(src_en & (src_en - N_SRC'(1)));
    assign idleVal = (HOLD_IDLE != 0) ? lastVal : '0;

    // Remember the last value and index that actually drove the bus; these
    // feed the idle hold value and the held select in both output modes.
    always_ff @(posedge clock) begin
        if (clear) begin
            lastVal <= '0;
            selReg  <= '0;
        end else if (anyEn) begin
            lastVal <= winData;
            selReg  <= winSel;
        end
    end

    // Sticky conflict flag. A new conflict on the same edge as a clear request
    // keeps the flag set so a simultaneous event is never lost.
    always_ff @(posedge clock) begin
        if (clear) begin
            conflictReg <= 1'b0;
        end else if (multiEn) begin
            conflictReg <= 1'b1;
        end else if (conflict_clr) begin
            conflictReg <= 1'b0;
        end
    end

    assign conflict = conflictReg;

    generate
        if (REG_OUT != 0) begin : gRegOut
            logic [WIDTH-1:0] outReg;
            logic             validReg;

            // Registered bus stage. The select register above already has the
            // right hold behaviour, so only data and valid live here.
            always_ff @(posedge clock) begin
                if (clear) begin
                    outReg   <= '0;
                    validReg <= 1'b0;
                end else begin
                    validReg <= anyEn;
                    outReg   <= anyEn ? winData : idleVal;
                end
            end

            assign bus_out   = outReg;
            assign bus_valid = validReg;
            assign bus_sel   = selReg;
        end else begin : gCombOut
            assign bus_out   = anyEn ? winData : idleVal;
            assign bus_valid = anyEn;
            assign bus_sel   = anyEn ? winSel : selReg;
        end
    endgenerate

`ifdef BUS_CONFLICT_CNT_EN
    logic [7:0]       cntReg;
    logic [N_SRC-1:0] srcReg;
    logic             srcCaptured;

    // Conflict statistics. conflict_clr restarts the window, and a conflict
    // on that same edge is treated as the first event of the new window.
    always_ff @(posedge clock) begin
        if (clear) begin
            cntReg      <= '0;
            srcReg      <= '0;
            srcCaptured <= 1'b0;
        end else if (conflict_clr) begin
            cntReg      <= multiEn ? 8'd1 : 8'd0;
            srcReg      <= multiEn ? src_en : '0;
            srcCaptured <= multiEn;
        end else if (multiEn) begin
            if (cntReg != 8'hFF) begin
                cntReg <= cntReg + 8'd1;
            end
            if (!srcCaptured) begin
                srcReg      <= src_en;
                srcCaptured <= 1'b1;
            end
        end
    end

    assign conflict_cnt = cntReg;
    assign conflict_src = srcReg;
`endif

endmodule
